sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 128 ++++++++++++
 tb/tb_sync_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered or first-word-fall-through read port
// Build option: define SYNC_FIFO_ERR_FLAGS_EN for sticky wr_overflow / rd_underflow flags.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  wr_overflow,
    output logic                  rd_underflow
);
    localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_next;
    logic [ADDR_WIDTH:0]   rd_ptr_next;
    logic [ADDR_WIDTH:0]   level_next;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  full_next;
    logic                  empty_next;
    logic [DATA_WIDTH-1:0] head_data;

    // Full blocks the write and empty blocks the read, which resolves the
    // simultaneous write+read corner cases without extra priority logic.
    assign wr_accept = wr_en && !wr_full;
    assign rd_accept = rd_en && !rd_empty;
    assign head_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_comb begin
        wr_ptr_next = wr_accept ? wr_ptr + CNT_ONE : wr_ptr;
        rd_ptr_next = rd_accept ? rd_ptr + CNT_ONE : rd_ptr;
        level_next  = level;
        if (wr_accept && !rd_accept) begin
            level_next = level + CNT_ONE;
        end else if (!wr_accept && rd_accept) begin
            level_next = level - CNT_ONE;
        end
        empty_next = (wr_ptr_next == rd_ptr_next);
        full_next  = (wr_ptr_next[ADDR_WIDTH-1:0] == rd_ptr_next[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_next[ADDR_WIDTH] != rd_ptr_next[ADDR_WIDTH]);
    end

    // Flags are computed from next-state values so they line up with level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            wr_full         <= 1'b0;
            wr_almost_full  <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
        end else begin
            wr_ptr          <= wr_ptr_next;
            rd_ptr          <= rd_ptr_next;
            level           <= level_next;
            wr_full         <= full_next;
            wr_almost_full  <= (level_next >= AF_LEVEL);
            rd_empty        <= empty_next;
            rd_almost_empty <= (level_next <= AE_LEVEL);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Gate with rd_empty so reset presents zero rather than stale memory.
            assign rd_data  = rd_empty ? '0 : head_data;
            assign rd_valid = !rd_empty;
        end else begin : g_registered
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_accept;
                    if (rd_accept) begin
                        rd_data <= head_data;
                    end
                end
            end
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            if (wr_en && wr_full) begin
                wr_overflow <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end
`else
    assign wr_overflow  = 1'b0;
    assign rd_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - randomized queue-model bench for sync_fifo, registered and FWFT builds
`timescale 1ns/1ps
module tb_sync_fifo;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;

    logic       a_full, a_afull, a_valid, a_empty, a_aempty, a_ovf, a_unf;
    logic [7:0] a_data;
    logic [4:0] a_level;
    logic       b_full, b_afull, b_valid, b_empty, b_aempty, b_ovf, b_unf;
    logic [7:0] b_data;
    logic [4:0] b_level;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q[$];
    logic [7:0] exp_rd_a = '0;
    bit         exp_ovf  = 1'b0;
    bit         exp_unf  = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(.FWFT(1'b0)) u_dut_reg (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(a_full), .wr_almost_full(a_afull), .rd_en(rd_en), .rd_data(a_data),
        .rd_valid(a_valid), .rd_empty(a_empty), .rd_almost_empty(a_aempty),
        .level(a_level), .wr_overflow(a_ovf), .rd_underflow(a_unf)
    );

    sync_fifo #(.FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(b_full), .wr_almost_full(b_afull), .rd_en(rd_en), .rd_data(b_data),
        .rd_valid(b_valid), .rd_empty(b_empty), .rd_almost_empty(b_aempty),
        .level(b_level), .wr_overflow(b_ovf), .rd_underflow(b_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input bit popped);
        int sz;
        sz = q.size();
        check("level",        32'(a_level),  32'(sz));
        check("rd_empty",     32'(a_empty),  32'(sz == 0));
        check("wr_full",      32'(a_full),   32'(sz == DEPTH));
        check("almost_full",  32'(a_afull),  32'(sz >= DEPTH - 2));
        check("almost_empty", 32'(a_aempty), 32'(sz <= 2));
        check("wr_overflow",  32'(a_ovf),    32'(exp_ovf));
        check("rd_underflow", 32'(a_unf),    32'(exp_unf));
        check("reg_rd_valid", 32'(a_valid),  32'(popped));
        check("reg_rd_data",  32'(a_data),   32'(exp_rd_a));
        check("fwft_level",   32'(b_level),  32'(sz));
        check("fwft_full",    32'(b_full),   32'(sz == DEPTH));
        check("fwft_valid",   32'(b_valid),  32'(sz > 0));
        if (sz > 0) begin
            check("fwft_rd_data", 32'(b_data), 32'(q[0]));
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
        int sz;
        bit wa, ra;
        sz = q.size();
        wa = we && (sz < DEPTH);
        ra = re && (sz > 0);
        if (we && sz == DEPTH) exp_ovf = ERR_EN;
        if (re && sz == 0) exp_unf = ERR_EN;
        if (ra) exp_rd_a = q.pop_front();
        if (wa) q.push_back(wd);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(ra);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"},     32'(a_level),  32'd0);
        check({tag, "_empty"},     32'(a_empty),  32'd1);
        check({tag, "_aempty"},    32'(a_aempty), 32'd1);
        check({tag, "_full"},      32'(a_full),   32'd0);
        check({tag, "_afull"},     32'(a_afull),  32'd0);
        check({tag, "_valid"},     32'(a_valid),  32'd0);
        check({tag, "_data"},      32'(a_data),   32'd0);
        check({tag, "_ovf"},       32'(a_ovf),    32'd0);
        check({tag, "_unf"},       32'(a_unf),    32'd0);
        check({tag, "_fwft_lvl"},  32'(b_level),  32'd0);
        check({tag, "_fwft_val"},  32'(b_valid),  32'd0);
        check({tag, "_fwft_data"}, 32'(b_data),   32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd_a = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("init");
        rst_n = 1'b1;

        // In-order write of 0..7 then eight reads.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

        // Fill to full, then one write while full.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0);

        // Simultaneous write+read while full: read wins.
        cycle(1'b1, 8'h77, 1'b1);
        check("full_rw_level", 32'(a_level), 32'd15);
        check("full_rw_word0", 32'(a_data), 32'd0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);

        // Read while empty, then simultaneous write+read while empty.
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h5A, 1'b1);
        check("empty_rw_level", 32'(a_level), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);

        // First-word-fall-through visibility.
        cycle(1'b1, 8'hA5, 1'b0);
        check("fwft_a5_data", 32'(b_data), 32'hA5);
        check("fwft_a5_valid", 32'(b_valid), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        check("fwft_pop_empty", 32'(b_empty), 32'd1);

        // Randomized interleaving with varying write bias to cross wrap, full and empty.
        for (int phase = 0; phase < 4; phase++) begin
            int wp;
            wp = (phase == 0) ? 80 : (phase == 1) ? 25 : 55;
            for (int i = 0; i < 60; i++) begin
                cycle(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < 50));
            end
        end

        // Asynchronous reset mid-operation with five words stored.
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        check("pre_reset_level", 32'(a_level), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end
endmodule
